// File: rtl/cal_ps_resp.sv
// rtl/cal_ps_resp.sv - DCM variable phase-shift port responder with bounded signed phase model
module cal_ps_resp #(
    parameter int PS_LATENCY = 12,
    parameter int PH_W       = 9,
    parameter int PS_MAX     = 255,
    parameter int PS_MIN     = -255,
    parameter int INIT_PHASE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dcmlocked,
    input  logic                   psEn,
    input  logic                   psInc,
    output logic                   psDone,
    output logic signed [PH_W-1:0] phase,
    output logic                   psOverflow,
    output logic                   busy,
    output logic                   protoErr
);

    localparam logic signed [PH_W-1:0] PHASE_MAX  = PH_W'(PS_MAX);
    localparam logic signed [PH_W-1:0] PHASE_MIN  = PH_W'(PS_MIN);
    localparam logic signed [PH_W-1:0] PHASE_INIT = PH_W'(INIT_PHASE);
    localparam logic [7:0]             LAT_LOAD   = 8'(PS_LATENCY - 2);

    if (PS_LATENCY < 2 || PS_LATENCY > 255) begin : gBadLatency
        $error("cal_ps_resp: PS_LATENCY must lie in 2..255");
    end
    if (PS_MAX > (2 ** (PH_W - 1)) - 1 || PS_MIN < -(2 ** (PH_W - 1)) || PS_MIN > PS_MAX) begin : gBadLimits
        $error("cal_ps_resp: PS_MIN/PS_MAX not representable in PH_W bits or inverted");
    end
    if (INIT_PHASE < PS_MIN || INIT_PHASE > PS_MAX) begin : gBadInit
        $error("cal_ps_resp: INIT_PHASE outside [PS_MIN, PS_MAX]");
    end

    typedef enum logic [1:0] {
        sIdle,
        sWait,
        sDone
    } psState_t;

    psState_t   state;
    psState_t   nextState;
    logic [7:0] latCnt;
    logic       dirInc;
    logic       accept;
    logic       enterDone;

    assign accept    = (state == sIdle) && psEn && dcmlocked;
    assign enterDone = (state == sWait) && (latCnt == 8'd0) && dcmlocked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= sIdle;
        end else begin
            state <= nextState;
        end
    end

    // Losing lock while waiting abandons the request silently.
    always_comb begin
        nextState = state;
        case (state)
            sIdle:   if (accept) nextState = sWait;
            sWait:   if (!dcmlocked) nextState = sIdle;
                     else if (latCnt == 8'd0) nextState = sDone;
            sDone:   nextState = sIdle;
            default: nextState = sIdle;
        endcase
    end

    always_comb begin
        psDone = (state == sDone);
        busy   = (state != sIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latCnt     <= 8'd0;
            dirInc     <= 1'b0;
            phase      <= PHASE_INIT;
            psOverflow <= 1'b0;
            protoErr   <= 1'b0;
        end else begin
            if (accept) begin
                latCnt <= LAT_LOAD;
                dirInc <= psInc;
            end else if (state == sWait && latCnt != 8'd0) begin
                latCnt <= latCnt - 8'd1;
            end

            if (psEn && state != sIdle) begin
                protoErr <= 1'b1;
            end

            // Limits are checked against the pre-update phase, so it saturates rather than wraps.
            if (enterDone) begin
                if (dirInc) begin
                    if (phase == PHASE_MAX) begin
                        psOverflow <= 1'b1;
                    end else begin
                        phase      <= phase + PH_W'(1);
                        psOverflow <= 1'b0;
                    end
                end else begin
                    if (phase == PHASE_MIN) begin
                        psOverflow <= 1'b1;
                    end else begin
                        phase      <= phase - PH_W'(1);
                        psOverflow <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
